uart_mm_responder: RTL and testbench



---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_rx_core.sv | 134 +++++++++++++
 rtl/uart_mm_responder.sv | 203 ++++++++++++++++++++
 tb/tb_uart_mm_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART responder.
//   tx_state_t / rx_state_t : transmitter and receiver FSM encodings
//   UART_*                  : register selectors (bus address bits [3:2])
//   STAT_*                  : bit positions inside the STATUS register
//   half_bit_reload()       : counter reload that lands a sample mid-bit
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_RXDATA = 2'd2;
    localparam logic [1:0] UART_DIV    = 2'd3;

    localparam int STAT_TX_BUSY      = 0;
    localparam int STAT_RX_VALID     = 1;
    localparam int STAT_RX_OVERRUN   = 2;
    localparam int STAT_RX_FRAME_ERR = 3;

    // A down-counter loaded with this value reaches zero floor(div/2)
    // cycles later. The divisor is never below 4, so no underflow.
    function automatic logic [15:0] half_bit_reload(input logic [15:0] div);
        return (div >> 1) - 16'd1;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: two-flop synchronizer, start/data/stop FSM, shift register.
//   clk, rst      : system clock, synchronous active-high reset
//   i_rx          : asynchronous serial input (idle high)
//   i_div         : clocks per bit, sampled at every counter reload
//   o_byte_done   : one-cycle pulse, o_byte holds a good byte
//   o_byte        : last assembled byte (stable until the next frame's data)
//   o_frame_err   : one-cycle pulse, stop bit was sampled low
module uart_rx_core
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rx,
    input  logic [15:0] i_div,
    output logic        o_byte_done,
    output logic [7:0]  o_byte,
    output logic        o_frame_err
);

    logic        r_sync_q1;
    logic        r_sync_q2;
    rx_state_t   r_state;
    rx_state_t   w_state_next;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic        r_stop_seen;
    logic        w_stop_seen_next;
    logic        r_byte_done;
    logic        w_byte_done_next;
    logic        r_frame_err;
    logic        w_frame_err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_q1   <= 1'b1;
            r_sync_q2   <= 1'b1;
            r_state     <= RX_IDLE;
            r_cnt       <= 16'd0;
            r_idx       <= 3'd0;
            r_shift     <= 8'd0;
            r_stop_seen <= 1'b0;
            r_byte_done <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync_q1   <= i_rx;
            r_sync_q2   <= r_sync_q1;
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_idx       <= w_idx_next;
            r_shift     <= w_shift_next;
            r_stop_seen <= w_stop_seen_next;
            r_byte_done <= w_byte_done_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_idx_next       = r_idx;
        w_shift_next     = r_shift;
        w_stop_seen_next = r_stop_seen;
        w_byte_done_next = 1'b0;
        w_frame_err_next = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (!r_sync_q2) begin
                    w_state_next = RX_START;
                    w_cnt_next   = half_bit_reload(i_div);
                end
            end
            RX_START: begin
                if (r_cnt == 16'd0) begin
                    // Line back high at mid start bit: treat as a glitch.
                    if (r_sync_q2) begin
                        w_state_next = RX_IDLE;
                    end else begin
                        w_state_next = RX_DATA;
                        w_cnt_next   = i_div - 16'd1;
                        w_idx_next   = 3'd0;
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            RX_DATA: begin
                if (r_cnt == 16'd0) begin
                    // LSB arrives first, so shift in from the top.
                    w_shift_next = {r_sync_q2, r_shift[7:1]};
                    w_cnt_next   = i_div - 16'd1;
                    if (r_idx == 3'd7) begin
                        w_state_next     = RX_STOP;
                        w_stop_seen_next = 1'b0;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            RX_STOP: begin
                if (r_cnt == 16'd0) begin
                    if (!r_stop_seen) begin
                        // Mid stop bit: judge the frame, then sit out the
                        // remaining half bit so a low stop cannot retrigger.
                        w_stop_seen_next = 1'b1;
                        w_cnt_next       = half_bit_reload(i_div);
                        if (r_sync_q2) begin
                            w_byte_done_next = 1'b1;
                        end else begin
                            w_frame_err_next = 1'b1;
                        end
                    end else begin
                        w_state_next = RX_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_next = RX_IDLE;
            end
        endcase
    end

    assign o_byte_done = r_byte_done;
    assign o_byte      = r_shift;
    assign o_frame_err = r_frame_err;

endmodule

// File: rtl/uart_mm_responder.sv
// Memory-mapped 8N1 UART responder on the core's data-memory bus.
//   clk, rst     : system clock, synchronous active-high reset
//   cs, re, we   : window select from the map controller, read/write strobes
//   A[3:2]       : register select (TXDATA, STATUS, RXDATA, DIV); A[1:0] unused
//   WD / RD      : write data / combinational read data (bits [15:0] used)
//   uart_rx      : asynchronous serial input
//   uart_tx      : serial output, idle high
// Reads are combinational; read side effects (flag clears) happen at the
// clock edge that ends the access, so a read always sees pre-edge values.
module uart_mm_responder
    import uart_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter logic [15:0] CLKS_PER_BIT = 16'd434,
    parameter logic [15:0] MIN_DIV      = 16'd4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  re,
    input  logic                  we,
    input  logic [3:0]            A,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD,
    input  logic                  uart_rx,
    output logic                  uart_tx
);

    logic [1:0]  w_reg;
    logic        w_sel_rd;
    logic        w_sel_wr;
    logic        w_tx_write;
    logic        w_div_write;
    logic        w_status_read;
    logic        w_rxdata_read;
    logic        w_tx_busy;
    logic        w_unused;

    logic [15:0] r_div;
    logic        r_rx_valid;
    logic        r_rx_overrun;
    logic        r_rx_frame_err;
    logic [7:0]  r_rx_data;

    logic        w_rx_byte_done;
    logic [7:0]  w_rx_byte;
    logic        w_rx_frame_err;

    tx_state_t   r_tx_state;
    tx_state_t   w_tx_state_next;
    logic [15:0] r_tx_cnt;
    logic [15:0] w_tx_cnt_next;
    logic [2:0]  r_tx_idx;
    logic [2:0]  w_tx_idx_next;
    logic [7:0]  r_tx_shift;
    logic [7:0]  w_tx_shift_next;
    logic        r_tx_line;
    logic        w_tx_line_next;

    assign w_unused = ^{WD[DATA_WIDTH-1:16], A[1:0]};

    assign w_reg         = A[3:2];
    assign w_sel_rd      = cs && re;
    assign w_sel_wr      = cs && we;
    assign w_tx_busy     = (r_tx_state != TX_IDLE);
    assign w_tx_write    = w_sel_wr && (w_reg == UART_TXDATA) && !w_tx_busy;
    assign w_div_write   = w_sel_wr && (w_reg == UART_DIV);
    assign w_status_read = w_sel_rd && (w_reg == UART_STATUS);
    assign w_rxdata_read = w_sel_rd && (w_reg == UART_RXDATA);

    uart_rx_core u_rx (
        .clk         (clk),
        .rst         (rst),
        .i_rx        (uart_rx),
        .i_div       (r_div),
        .o_byte_done (w_rx_byte_done),
        .o_byte      (w_rx_byte),
        .o_frame_err (w_rx_frame_err)
    );

    // Register file and receive flags. Setting events win over read clears
    // so a completion landing on a read edge is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div          <= CLKS_PER_BIT;
            r_rx_valid     <= 1'b0;
            r_rx_overrun   <= 1'b0;
            r_rx_frame_err <= 1'b0;
            r_rx_data      <= 8'd0;
        end else begin
            if (w_div_write) begin
                r_div <= (WD[15:0] < MIN_DIV) ? MIN_DIV : WD[15:0];
            end
            if (w_rx_byte_done) begin
                r_rx_data  <= w_rx_byte;
                r_rx_valid <= 1'b1;
            end else if (w_rxdata_read) begin
                r_rx_valid <= 1'b0;
            end
            if (w_rx_byte_done && r_rx_valid && !w_rxdata_read) begin
                r_rx_overrun <= 1'b1;
            end else if (w_status_read) begin
                r_rx_overrun <= 1'b0;
            end
            if (w_rx_frame_err) begin
                r_rx_frame_err <= 1'b1;
            end else if (w_status_read) begin
                r_rx_frame_err <= 1'b0;
            end
        end
    end

    // Transmitter state register. The line is registered from the next
    // state so it changes cleanly on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_idx   <= 3'd0;
            r_tx_shift <= 8'd0;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_idx   <= w_tx_idx_next;
            r_tx_shift <= w_tx_shift_next;
            r_tx_line  <= w_tx_line_next;
        end
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt;
        w_tx_idx_next   = r_tx_idx;
        w_tx_shift_next = r_tx_shift;
        w_tx_line_next  = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_tx_write) begin
                    w_tx_state_next = TX_START;
                    w_tx_cnt_next   = r_div - 16'd1;
                    w_tx_shift_next = WD[7:0];
                end
            end
            TX_START: begin
                if (r_tx_cnt == 16'd0) begin
                    w_tx_state_next = TX_DATA;
                    w_tx_cnt_next   = r_div - 16'd1;
                    w_tx_idx_next   = 3'd0;
                end else begin
                    w_tx_cnt_next = r_tx_cnt - 16'd1;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == 16'd0) begin
                    w_tx_cnt_next = r_div - 16'd1;
                    if (r_tx_idx == 3'd7) begin
                        w_tx_state_next = TX_STOP;
                    end else begin
                        w_tx_idx_next = r_tx_idx + 3'd1;
                    end
                end else begin
                    w_tx_cnt_next = r_tx_cnt - 16'd1;
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == 16'd0) begin
                    w_tx_state_next = TX_IDLE;
                end else begin
                    w_tx_cnt_next = r_tx_cnt - 16'd1;
                end
            end
            default: begin
                w_tx_state_next = TX_IDLE;
            end
        endcase
        case (w_tx_state_next)
            TX_START: w_tx_line_next = 1'b0;
            TX_DATA:  w_tx_line_next = w_tx_shift_next[w_tx_idx_next];
            default:  w_tx_line_next = 1'b1;
        endcase
    end

    assign uart_tx = r_tx_line;

    always_comb begin
        RD = '0;
        if (w_sel_rd) begin
            case (w_reg)
                UART_STATUS: begin
                    RD[STAT_TX_BUSY]      = w_tx_busy;
                    RD[STAT_RX_VALID]     = r_rx_valid;
                    RD[STAT_RX_OVERRUN]   = r_rx_overrun;
                    RD[STAT_RX_FRAME_ERR] = r_rx_frame_err;
                end
                UART_RXDATA: RD[7:0]  = r_rx_data;
                UART_DIV:    RD[15:0] = r_div;
                default:     RD       = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mm_responder.sv
module tb_uart_mm_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        re;
    logic        we;
    logic [3:0]  A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        uart_rx;
    logic        uart_tx;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_mm_responder #(
        .DATA_WIDTH   (32),
        .CLKS_PER_BIT (16'd434),
        .MIN_DIV      (16'd4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .re      (re),
        .we      (we),
        .A       (A),
        .WD      (WD),
        .RD      (RD),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    localparam logic [3:0] ADDR_TXDATA = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_RXDATA = 4'h8;
    localparam logic [3:0] ADDR_DIV    = 4'hC;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
        @(negedge clk);
        cs = 1'b1; re = 1'b1; we = 1'b0; A = addr;
        #1 data = RD;
        @(posedge clk);
        #1;
        cs = 1'b0; re = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; re = 1'b0; A = addr; WD = data;
        @(posedge clk);
        #1;
        cs = 1'b0; we = 1'b0;
    endtask

    // Drives one 8N1 frame at 4 clocks per bit, then idles high.
    task automatic send_rx(input logic [7:0] data, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, data, 1'b0};
        @(posedge clk);
        #1;
        for (int b = 0; b < 10; b++) begin
            uart_rx = frame[b];
            repeat (4) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic [9:0]  tx_frame;
        int          low_count;

        rst = 1'b1; cs = 1'b0; re = 1'b0; we = 1'b0; A = 4'h0; WD = 32'h0; uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_rd_idle", RD, 32'd0);

        bus_read(ADDR_TXDATA, rd); check("rst_txdata", rd, 32'h0);
        bus_read(ADDR_STATUS, rd); check("rst_status", rd, 32'h0);
        bus_read(ADDR_RXDATA, rd); check("rst_rxdata", rd, 32'h0);
        bus_read(ADDR_DIV, rd);    check("rst_div", rd, 32'd434);

        bus_write(ADDR_DIV, 32'd1);
        bus_read(ADDR_DIV, rd);    check("div_clamp", rd, 32'd4);

        // Transmit 0xA5; watch line and busy every cycle, try a write at cycle 10.
        bus_write(ADDR_TXDATA, 32'hA5);
        tx_frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 40; i++) begin
            cs = 1'b1;
            if (i == 10) begin
                re = 1'b0; we = 1'b1; A = ADDR_TXDATA; WD = 32'h3C;
            end else begin
                re = 1'b1; we = 1'b0; A = ADDR_STATUS;
            end
            #1;
            check($sformatf("tx_bit_c%0d", i), {31'd0, uart_tx}, {31'd0, tx_frame[i/4]});
            if (i != 10) check($sformatf("tx_busy_c%0d", i), {31'd0, RD[0]}, 32'd1);
            @(posedge clk);
            #1;
        end
        cs = 1'b1; re = 1'b1; we = 1'b0; A = ADDR_STATUS;
        #1;
        check("tx_done_line", {31'd0, uart_tx}, 32'd1);
        check("tx_done_status", RD, 32'h0);
        cs = 1'b0; re = 1'b0;
        low_count = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (uart_tx == 1'b0) low_count++;
        end
        check("tx_no_second_frame", low_count, 32'd0);

        // Receive path.
        send_rx(8'h5A, 1'b1);
        bus_read(ADDR_STATUS, rd); check("rx1_status", rd, 32'h2);
        bus_read(ADDR_RXDATA, rd); check("rx1_data", rd, 32'h5A);
        bus_read(ADDR_STATUS, rd); check("rx1_status_clr", rd, 32'h0);

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus_read(ADDR_STATUS, rd); check("ovr_status", rd, 32'h6);
        bus_read(ADDR_STATUS, rd); check("ovr_status_clr", rd, 32'h2);
        bus_read(ADDR_RXDATA, rd); check("ovr_data", rd, 32'h22);
        bus_read(ADDR_STATUS, rd); check("ovr_final", rd, 32'h0);

        send_rx(8'h77, 1'b0);
        bus_read(ADDR_STATUS, rd); check("ferr_status", rd, 32'h8);
        bus_read(ADDR_STATUS, rd); check("ferr_status_clr", rd, 32'h0);
        bus_read(ADDR_RXDATA, rd); check("ferr_data_kept", rd, 32'h22);

        @(posedge clk);
        #1 uart_rx = 1'b0;
        @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        bus_read(ADDR_STATUS, rd); check("glitch_status", rd, 32'h0);
        bus_read(ADDR_RXDATA, rd); check("glitch_data", rd, 32'h22);

        // Write and read on the same edge: read sees the old divisor.
        @(negedge clk);
        cs = 1'b1; we = 1'b1; re = 1'b1; A = ADDR_DIV; WD = 32'd8;
        #1 check("rw_same_edge", RD, 32'd4);
        @(posedge clk);
        #1;
        cs = 1'b0; we = 1'b0; re = 1'b0;
        bus_read(ADDR_DIV, rd); check("div_after_rw", rd, 32'd8);

        // Reset in the middle of a frame (DIV=8, data bit 0 of 0x00 is low).
        bus_write(ADDR_TXDATA, 32'h00);
        repeat (14) @(posedge clk);
        #1;
        check("tx_mid_frame_low", {31'd0, uart_tx}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_uart_tx", {31'd0, uart_tx}, 32'd1);
        rst = 1'b0;
        bus_read(ADDR_STATUS, rd); check("rst_mid_status", rd, 32'h0);
        bus_read(ADDR_DIV, rd);    check("rst_mid_div", rd, 32'd434);
        bus_read(ADDR_RXDATA, rd); check("rst_mid_rxdata", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
